dtree_node_sched: RTL and testbench

DTREE_NODE_SCHED -- requirements
Module: dtree_node_sched

---
 rtl/dtree_node_sched.sv | 131 +++++++++++++
 tb/tb_dtree_node_sched.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/dtree_node_sched.sv
// dtree_node_sched: buffers one sample of features, walks a decision tree, returns the class
module dtree_node_sched #(
    parameter int NFEAT    = 20,
    parameter int FW       = 8,
    parameter int AW       = 7,
    parameter int CW       = 2,
    parameter int MAXDEPTH = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ft_valid,
    output logic          ft_ready,
    input  logic [FW-1:0] ft_data,
    output logic [AW-1:0] node_addr,
    input  logic [29:0]   node_data,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [CW-1:0] res_class,
    output logic          res_err,
    output logic          busy
);
    localparam int CNTW = NFEAT > 1 ? $clog2(NFEAT) : 1;
    localparam int DW   = $clog2(MAXDEPTH + 1);
    localparam logic [1:0] S_LOAD = 2'd0;
    localparam logic [1:0] S_WALK = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    logic [1:0]      state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [DW-1:0]   depth_q, depth_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            valid_q, valid_d;
    logic [CW-1:0]   class_q, class_d;
    logic            err_q, err_d;
    logic            ft_ready_q, ft_ready_d;
    logic            busy_q, busy_d;
    logic [FW-1:0]   feat_q [NFEAT];
    logic [7:0]      fval;
    logic [7:0]      cmp;
    logic [AW-1:0]   child;
    // Feature selection: out-of-range indices read as zero
    always_comb begin
        fval = '0;
        for (int i = 0; i < NFEAT; i++)
            if (node_data[28:24] == 5'(i)) fval = 8'(feat_q[i]);
        cmp = node_data[23:22] == 2'd0 ? fval >> 6 :
              node_data[23:22] == 2'd1 ? fval >> 5 :
              node_data[23:22] == 2'd2 ? fval >> 4 : fval;
        child = AW'(cmp <= node_data[21:14] ? node_data[13:7] : node_data[6:0]);
    end
    // Next-state logic for the LOAD / WALK / DONE sequence
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        depth_d = depth_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        class_d = class_q;
        err_d   = err_q;
        if (state_q == S_LOAD) begin
            if (ft_valid) begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNTW'(NFEAT - 1)) begin
                    state_d = S_WALK;
                    cnt_d   = '0;
                    addr_d  = '0;
                    depth_d = '0;
                end
            end
        end else if (state_q == S_WALK) begin
            if (node_data[29]) begin
                class_d = node_data[CW-1:0];
                err_d   = 1'b0;
                valid_d = 1'b1;
                state_d = S_DONE;
            end else if (depth_q == DW'(MAXDEPTH)) begin
                class_d = '0;
                err_d   = 1'b1;
                valid_d = 1'b1;
                state_d = S_DONE;
            end else begin
                addr_d  = child;
                depth_d = depth_q + 1'b1;
            end
        end else if (res_ready) begin
            state_d = S_LOAD;
            cnt_d   = '0;
            valid_d = 1'b0;
        end
        ft_ready_d = state_d == S_LOAD;
        busy_d     = state_d != S_LOAD;
    end
    // Control and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_LOAD;
            cnt_q      <= '0;
            depth_q    <= '0;
            addr_q     <= '0;
            valid_q    <= 1'b0;
            class_q    <= '0;
            err_q      <= 1'b0;
            ft_ready_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            depth_q    <= depth_d;
            addr_q     <= addr_d;
            valid_q    <= valid_d;
            class_q    <= class_d;
            err_q      <= err_d;
            ft_ready_q <= ft_ready_d;
            busy_q     <= busy_d;
        end
    end
    // Feature storage, written only while loading a sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NFEAT; i++) feat_q[i] <= '0;
        end else begin
            for (int i = 0; i < NFEAT; i++)
                if (state_q == S_LOAD && ft_valid && cnt_q == CNTW'(i)) feat_q[i] <= ft_data;
        end
    end
    assign ft_ready  = ft_ready_q;
    assign node_addr = addr_q;
    assign res_valid = valid_q;
    assign res_class = class_q;
    assign res_err   = err_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_dtree_node_sched.sv
// tb_dtree_node_sched: directed vector table plus reset/backpressure sequences
module tb_dtree_node_sched;
    logic        clk = 0, rst_n = 0, ft_valid = 0, res_ready = 0;
    logic [7:0]  ft_data = 0;
    logic        ft_ready, res_valid, res_err, busy;
    logic [6:0]  node_addr;
    logic [29:0] node_data;
    logic [1:0]  res_class;
    logic [29:0] mem [128];
    logic [7:0]  feat [20];
    int total = 0, passed = 0, rises = 0;

    dtree_node_sched dut (
        .clk(clk), .rst_n(rst_n), .ft_valid(ft_valid), .ft_ready(ft_ready), .ft_data(ft_data),
        .node_addr(node_addr), .node_data(node_data), .res_valid(res_valid), .res_ready(res_ready),
        .res_class(res_class), .res_err(res_err), .busy(busy)
    );

    assign node_data = mem[node_addr];
    always #5 clk = ~clk;
    always @(posedge res_valid) rises++;

    typedef struct {
        logic [29:0] n0, n1, n2, n3;
        int oi;
        logic [7:0] ov;
        int cls, err, lat;
    } vec_t;
    vec_t vt [11];

    function automatic logic [29:0] inode(int f, int k, int t, int l, int r);
        return {1'b0, 5'(f), 2'(k), 8'(t), 7'(l), 7'(r)};
    endfunction
    function automatic logic [29:0] leaf(int c);
        return {1'b1, 27'd0, 2'(c)};
    endfunction

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic set_tbl(logic [29:0] n0, n1, n2, n3);
        for (int i = 0; i < 128; i++) mem[i] = leaf(0);
        mem[0] = n0; mem[1] = n1; mem[2] = n2; mem[3] = n3;
    endtask

    task automatic set_feats(int oi, logic [7:0] ov);
        for (int k = 0; k < 20; k++) feat[k] = 8'(k + 1);
        if (oi < 20) feat[oi] = ov;
    endtask

    task automatic send(int from, int to);
        for (int k = from; k < to; k++) begin
            int w = 0;
            while (!ft_ready && w < 50) begin @(posedge clk); #1; w++; end
            if (w == 50) chk("ft_ready_timeout", 0, 1);
            ft_valid = 1; ft_data = feat[k];
            @(posedge clk); #1;
        end
        ft_valid = 0;
    endtask

    task automatic wait_res(output int n);
        n = 1;
        while (!res_valid && n < 200) begin @(posedge clk); #1; n++; end
    endtask

    task automatic ack();
        res_ready = 1;
        @(posedge clk); #1;
        res_ready = 0;
    endtask

    initial begin
        int n, ok, r0;
        vt[0]  = '{inode(7,0,3,1,2),   leaf(1), leaf(3), leaf(0), 7,  8'hC0, 1, 0, 3};
        vt[1]  = '{inode(7,0,2,1,2),   leaf(1), leaf(3), leaf(0), 7,  8'hC0, 3, 0, 3};
        vt[2]  = '{inode(12,1,2,1,2),  leaf(1), leaf(3), leaf(0), 12, 8'h5F, 1, 0, 3};
        vt[3]  = '{inode(12,1,1,1,2),  leaf(1), leaf(3), leaf(0), 12, 8'h5F, 3, 0, 3};
        vt[4]  = '{inode(3,2,10,1,2),  leaf(1), leaf(3), leaf(0), 3,  8'hA7, 1, 0, 3};
        vt[5]  = '{inode(19,3,127,1,2),leaf(1), leaf(3), leaf(0), 19, 8'h80, 3, 0, 3};
        vt[6]  = '{inode(25,3,0,1,2),  leaf(1), leaf(3), leaf(0), 99, 8'h00, 1, 0, 3};
        vt[7]  = '{inode(0,3,255,1,1), inode(1,3,0,2,3), leaf(0), leaf(2), 99, 8'h00, 2, 0, 4};
        vt[8]  = '{leaf(2),            leaf(1), leaf(3), leaf(0), 99, 8'h00, 2, 0, 2};
        vt[9]  = '{inode(0,0,0,0,0),   leaf(1), leaf(3), leaf(0), 99, 8'h00, 0, 1, 17};
        vt[10] = '{inode(5,3,200,1,2), leaf(0), leaf(3), leaf(0), 5,  8'hC8, 0, 0, 3};
        set_tbl(leaf(0), leaf(0), leaf(0), leaf(0));
        set_feats(99, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_class", res_class, 0);
        chk("rst_res_err", res_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_node_addr", node_addr, 0);
        rst_n = 1;
        @(posedge clk); #1;
        chk("post_rst_ft_ready", ft_ready, 1);

        for (int i = 0; i < 11; i++) begin
            set_tbl(vt[i].n0, vt[i].n1, vt[i].n2, vt[i].n3);
            set_feats(vt[i].oi, vt[i].ov);
            send(0, 20);
            wait_res(n);
            $display("vector %0d: class %0d err %0d latency %0d", i, res_class, res_err, n);
            chk("vec_class", res_class, vt[i].cls);
            chk("vec_err", res_err, vt[i].err);
            chk("vec_latency", n, vt[i].lat);
            chk("vec_busy_done", busy, 1);
            ack();
            chk("vec_valid_cleared", res_valid, 0);
            chk("vec_ft_ready_back", ft_ready, 1);
            chk("vec_busy_idle", busy, 0);
        end

        set_tbl(vt[0].n0, vt[0].n1, vt[0].n2, vt[0].n3);
        set_feats(7, 8'hC0);
        send(0, 20);
        wait_res(n);
        ft_valid = 1; ft_data = 8'hFF; ok = 1;
        repeat (10) begin
            @(posedge clk); #1;
            if (res_valid !== 1 || res_class !== 2'd1 || res_err !== 0 || ft_ready !== 0) ok = 0;
        end
        chk("hold_stable", ok, 1);
        ft_valid = 0;
        ack();
        chk("hold_release_ft_ready", ft_ready, 1);
        set_tbl(vt[1].n0, vt[1].n1, vt[1].n2, vt[1].n3);
        send(0, 19);
        chk("hold_cnt_restart_19", busy, 0);
        send(19, 20);
        wait_res(n);
        chk("hold_next_class", res_class, 3);
        chk("hold_next_latency", n, 3);
        ack();

        r0 = rises;
        set_feats(7, 8'h00);
        send(0, 11);
        rst_n = 0; #3;
        chk("mid_load_rst_busy", busy, 0);
        rst_n = 1;
        @(posedge clk); #1;
        chk("mid_load_rst_ft_ready", ft_ready, 1);
        set_feats(7, 8'hC0);
        send(0, 20);
        wait_res(n);
        chk("mid_load_class", res_class, 3);
        chk("mid_load_latency", n, 3);
        ack();
        chk("mid_load_one_result", rises - r0, 1);

        r0 = rises;
        set_tbl(vt[9].n0, vt[9].n1, vt[9].n2, vt[9].n3);
        send(0, 20);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 0; #1;
        chk("mid_walk_rst_busy", busy, 0);
        rst_n = 1;
        repeat (20) @(posedge clk);
        #1;
        chk("mid_walk_no_result", rises - r0, 0);
        chk("mid_walk_ft_ready", ft_ready, 1);

        set_tbl(vt[0].n0, vt[0].n1, vt[0].n2, vt[0].n3);
        send(0, 20);
        wait_res(n);
        chk("done_pre_rst_valid", res_valid, 1);
        rst_n = 0; #1;
        chk("done_rst_valid", res_valid, 0);
        chk("done_rst_class", res_class, 0);
        rst_n = 1;
        @(posedge clk); #1;
        chk("done_rst_ft_ready", ft_ready, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
